// File: rtl/branch_predict_unit.sv
// Branch predictor and resolver between IF, ID and EX: BHT of saturating
// counters for ID prediction, EX condition resolution, flush and next-PC select.
module branch_predict_unit #(
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_W       = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic              id_branch,
    input  logic              id_uncond,
    input  logic [ADDR_W-1:0] id_target,
    input  logic [ADDR_W-1:0] npc,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [2:0]        ex_cond,
    input  logic              ex_z,
    input  logic              ex_n,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic [ADDR_W-1:0] ex_fallthru,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              flush,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0]  bht_q [BHT_ENTRIES];
    logic [CTR_W-1:0]  bht_d [BHT_ENTRIES];
    logic [STAT_W-1:0] cnt_q;
    logic [STAT_W-1:0] cnt_d;
    logic [IDX_W-1:0]  id_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic [CTR_W-1:0]  ex_ctr;
    logic              actual_taken;
    logic              mispredict;
    logic              unused_pc;

    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc = ^{id_pc[ADDR_W-1:IDX_W+2], id_pc[1:0],
                         ex_pc[ADDR_W-1:IDX_W+2], ex_pc[1:0]};
    assign mispredict_cnt = cnt_q;

    always_comb begin
        actual_taken = 1'b0;
        unique case (ex_cond)
            3'd0: actual_taken = ex_z;
            3'd1: actual_taken = !ex_z;
            3'd2: actual_taken = ex_z | ex_n;
            3'd3: actual_taken = !ex_z & !ex_n;
            3'd4: actual_taken = ex_n;
            3'd5: actual_taken = !ex_n;
            3'd6: actual_taken = 1'b1;
            3'd7: actual_taken = 1'b0;
        endcase
    end

    // Reset masks every redirect so IF simply follows npc.
    always_comb begin
        mispredict = !reset & ex_valid & (actual_taken != ex_pred_taken);
        pred_taken = !reset & id_valid
                   & (id_uncond | (id_branch & bht_q[id_idx][CTR_W-1]));
        flush      = mispredict;
        next_pc    = npc;
        if (mispredict) begin
            next_pc = actual_taken ? ex_target : ex_fallthru;
        end else if (pred_taken) begin
            next_pc = id_target;
        end
    end

    always_comb begin
        bht_d  = bht_q;
        cnt_d  = cnt_q;
        ex_ctr = bht_q[ex_idx];
        if (ex_valid && ex_cond < 3'd6) begin
            if (actual_taken && ex_ctr != CTR_MAX) begin
                bht_d[ex_idx] = ex_ctr + 1'b1;
            end else if (!actual_taken && ex_ctr != '0) begin
                bht_d[ex_idx] = ex_ctr - 1'b1;
            end
        end
        if (mispredict && cnt_q != STAT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_INIT;
            end
            cnt_q <= '0;
        end else begin
            bht_q <= bht_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus
// randomized traffic against a behavioural predictor model.
module tb_branch_predict_unit;

    localparam int ENTRIES  = 16;
    localparam int CTR_MAX  = 3;
    localparam int CTR_INIT = 1;
    localparam int STAT_MAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_branch, id_uncond;
    logic [31:0] id_pc, id_target, npc;
    logic        ex_valid, ex_z, ex_n, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_fallthru;
    logic [2:0]  ex_cond;
    logic        pred_taken, flush;
    logic [31:0] next_pc;
    logic [1:0]  mispredict_cnt;

    int bht_m [ENTRIES];
    int cnt_m;
    int passed = 0;
    int total  = 0;

    branch_predict_unit #(
        .ADDR_W(32), .BHT_ENTRIES(ENTRIES), .CTR_W(2), .STAT_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_branch(id_branch),
        .id_uncond(id_uncond), .id_target(id_target), .npc(npc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_cond(ex_cond),
        .ex_z(ex_z), .ex_n(ex_n), .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target), .ex_fallthru(ex_fallthru),
        .pred_taken(pred_taken), .next_pc(next_pc), .flush(flush),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit cond_f(int c, bit z, bit n);
        case (c)
            0: return z;
            1: return !z;
            2: return z || n;
            3: return !z && !n;
            4: return n;
            5: return !n;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit exp_pred();
        if (reset || !id_valid) return 1'b0;
        if (id_uncond) return 1'b1;
        return id_branch && bht_m[idx_of(id_pc)] > CTR_MAX / 2;
    endfunction

    function automatic bit exp_mis();
        if (reset || !ex_valid) return 1'b0;
        return cond_f(int'(ex_cond), ex_z, ex_n) != ex_pred_taken;
    endfunction

    function automatic logic [31:0] exp_npc();
        if (exp_mis())
            return cond_f(int'(ex_cond), ex_z, ex_n) ? ex_target : ex_fallthru;
        if (exp_pred()) return id_target;
        return npc;
    endfunction

    task automatic model_update();
        int  i;
        bit  act;
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) bht_m[k] = CTR_INIT;
            cnt_m = 0;
        end else begin
            act = cond_f(int'(ex_cond), ex_z, ex_n);
            i = idx_of(ex_pc);
            if (ex_valid && ex_cond < 6) begin
                if (act && bht_m[i] < CTR_MAX) bht_m[i]++;
                if (!act && bht_m[i] > 0) bht_m[i]--;
            end
            if (exp_mis() && cnt_m < STAT_MAX) cnt_m++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_branch = 0; id_uncond = 0;
        id_pc = 0; id_target = 0; npc = 32'h1000;
        ex_valid = 0; ex_pc = 0; ex_cond = 3'd7; ex_z = 0; ex_n = 0;
        ex_pred_taken = 0; ex_target = 0; ex_fallthru = 0;
    endtask

    task automatic set_ex(logic [31:0] pc, logic [2:0] c, bit z, bit n,
                          bit p, logic [31:0] t, logic [31:0] f);
        ex_valid = 1; ex_pc = pc; ex_cond = c; ex_z = z; ex_n = n;
        ex_pred_taken = p; ex_target = t; ex_fallthru = f;
    endtask

    task automatic lookup(logic [31:0] pc);
        clear_inputs();
        id_valid = 1; id_branch = 1; id_pc = pc;
        id_target = pc + 32'h100; npc = pc + 4;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        set_ex(32'h40, 3'd0, 1, 0, 0, 32'h80, 32'h44);
        id_valid = 1; id_uncond = 1; id_target = 32'h200;
        npc = $urandom;
        #1;
        total++;
        if (flush !== 1'b0 || pred_taken !== 1'b0 || next_pc !== npc)
            $display("FAIL reset_outputs flush=%b pred=%b npc=%h exp 0/0/%h",
                     flush, pred_taken, next_pc, npc);
        else passed++;
        cycle();
        cycle();
        reset = 0;
        lookup(32'h40);
        total++;
        if (pred_taken !== 1'b0 || next_pc !== 32'h44 || mispredict_cnt !== 2'd0)
            $display("FAIL reset_lookup pred=%b npc=%h cnt=%0d exp 0/44/0",
                     pred_taken, next_pc, mispredict_cnt);
        else passed++;
    endtask

    task automatic test_train();
        for (int i = 0; i < 2; i++) begin
            lookup(32'h40);
            set_ex(32'h40, 3'd0, 1, 0, 0, 32'h80, 32'h44);
            #1;
            total++;
            if (flush !== 1'b1 || next_pc !== 32'h80 || pred_taken !== (i == 1))
                $display("FAIL train_%0d flush=%b npc=%h pred=%b exp 1/80/%0d",
                         i, flush, next_pc, pred_taken, i);
            else passed++;
            cycle();
        end
        lookup(32'h40);
        total++;
        if (pred_taken !== 1'b1 || mispredict_cnt !== 2'd2)
            $display("FAIL train_after pred=%b cnt=%0d exp 1/2",
                     pred_taken, mispredict_cnt);
        else passed++;
    endtask

    task automatic test_priority();
        clear_inputs();
        id_valid = 1; id_uncond = 1; id_pc = 32'h60; id_target = 32'h200;
        set_ex(32'h140, 3'd1, 1, 0, 1, 32'h300, 32'h104);
        #1;
        total++;
        if (next_pc !== 32'h104 || flush !== 1'b1)
            $display("FAIL priority npc=%h flush=%b exp 104/1", next_pc, flush);
        else passed++;
        cycle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            set_ex(32'h48, 3'd0, 1, 0, 1, 32'h90, 32'h4c);
            #1;
            total++;
            if (flush !== 1'b0)
                $display("FAIL sat_taken_%0d flush=%b exp 0", i, flush);
            else passed++;
            cycle();
        end
        lookup(32'h48);
        set_ex(32'h48, 3'd0, 0, 0, 1, 32'h90, 32'h4c);
        #1;
        total++;
        if (pred_taken !== 1'b1 || next_pc !== 32'h4c || flush !== 1'b1)
            $display("FAIL sat_high pred=%b npc=%h flush=%b exp 1/4c/1",
                     pred_taken, next_pc, flush);
        else passed++;
        cycle();
        lookup(32'h48);
        total++;
        if (pred_taken !== 1'b1)
            $display("FAIL sat_ctr2 pred=%b exp 1", pred_taken);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            set_ex(32'h48, 3'd0, 0, 0, 0, 32'h90, 32'h4c);
            cycle();
        end
        lookup(32'h48);
        total++;
        if (pred_taken !== 1'b0)
            $display("FAIL sat_low pred=%b exp 0", pred_taken);
        else passed++;
        clear_inputs();
        set_ex(32'h48, 3'd0, 1, 0, 0, 32'h90, 32'h4c);
        cycle();
        lookup(32'h48);
        total++;
        if (pred_taken !== 1'b0)
            $display("FAIL sat_floor pred=%b exp 0", pred_taken);
        else passed++;
    endtask

    task automatic test_always_never();
        clear_inputs();
        set_ex(32'h50, 3'd6, 0, 0, 0, 32'h500, 32'h54);
        #1;
        total++;
        if (flush !== 1'b1 || next_pc !== 32'h500)
            $display("FAIL always flush=%b npc=%h exp 1/500", flush, next_pc);
        else passed++;
        cycle();
        lookup(32'h50);
        total++;
        if (pred_taken !== 1'b0)
            $display("FAIL always_noupd pred=%b exp 0", pred_taken);
        else passed++;
        clear_inputs();
        set_ex(32'h50, 3'd7, 0, 0, 0, 32'h500, 32'h54);
        npc = 32'h777;
        #1;
        total++;
        if (flush !== 1'b0 || next_pc !== 32'h777)
            $display("FAIL never flush=%b npc=%h exp 0/777", flush, next_pc);
        else passed++;
        cycle();
    endtask

    task automatic test_stat_reset();
        clear_inputs();
        reset = 1;
        set_ex(32'h40, 3'd0, 1, 0, 0, 32'h80, 32'h44);
        cycle();
        reset = 0;
        clear_inputs();
        #1;
        total++;
        if (mispredict_cnt !== 2'd0)
            $display("FAIL rst_cnt cnt=%0d exp 0", mispredict_cnt);
        else passed++;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup(32'(i * 4));
            total++;
            if (pred_taken !== 1'b0)
                $display("FAIL rst_bht_%0d pred=%b exp 0", i, pred_taken);
            else passed++;
        end
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            set_ex(32'(i * 8), 3'd6, 0, 0, 0, 32'h600, 32'h604);
            cycle();
        end
        clear_inputs();
        #1;
        total++;
        if (mispredict_cnt !== 2'd3)
            $display("FAIL stat_sat cnt=%0d exp 3", mispredict_cnt);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            id_valid = $urandom; id_branch = $urandom; id_uncond = ($urandom_range(0, 3) == 0);
            id_pc = 32'($urandom_range(0, 63)) << 2;
            id_target = $urandom; npc = $urandom;
            ex_valid = $urandom;
            ex_pc = 32'($urandom_range(0, 63)) << 2;
            ex_cond = 3'($urandom_range(0, 7));
            ex_z = $urandom; ex_n = $urandom; ex_pred_taken = $urandom;
            ex_target = $urandom; ex_fallthru = $urandom;
            #1;
            total++;
            if (pred_taken !== exp_pred() || flush !== exp_mis()
                || next_pc !== exp_npc() || mispredict_cnt !== 2'(cnt_m))
                $display("FAIL random_%0d pred=%b flush=%b npc=%h cnt=%0d exp %b/%b/%h/%0d",
                         i, pred_taken, flush, next_pc, mispredict_cnt,
                         exp_pred(), exp_mis(), exp_npc(), cnt_m);
            else passed++;
            cycle();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        cycle();
        test_reset();
        test_train();
        test_priority();
        test_saturation();
        test_always_never();
        test_stat_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
